// File: rtl/output_buffer_pkg.sv
// Shared constants and types for the output buffer and its storage array.
package output_buffer_pkg;

  // Default data word width in bits.
  localparam int OB_WIDTH = 256;

  // Default number of queued entries (power of two, at least 2).
  localparam int OB_DEPTH = 4;

  // Per-cycle queue operation, encoded as {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } ob_op_e;

endpackage : output_buffer_pkg

// File: rtl/output_buffer_mem.sv
// Storage array for output_buffer: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; the control
// logic never presents an unwritten entry on its output.
module output_buffer_mem
  import output_buffer_pkg::*;
#(
  parameter int WIDTH = OB_WIDTH,
  parameter int DEPTH = OB_DEPTH
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [WIDTH-1:0]         o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Capture the pushed word into the addressed entry.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : output_buffer_mem

// File: rtl/output_buffer.sv
// Output buffer: a small FIFO whose head word is held in a register, so
// every output comes straight from a flop. count includes the head word.
module output_buffer
  import output_buffer_pkg::*;
#(
  parameter int WIDTH = OB_WIDTH,
  parameter int DEPTH = OB_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       write_data,
  input  logic [WIDTH-1:0]           data_to_write,
  input  logic                       data_ready,
  input  logic                       clear_overflow,
  output logic [WIDTH-1:0]           data,
  output logic                       data_valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_full;
  logic             r_overflow;

  logic             w_push;
  logic             w_pop;
  ob_op_e           w_op;
  logic [CNT_W-1:0] w_count_next;
  logic [WIDTH-1:0] w_data_next;
  logic [PTR_W-1:0] w_rd_next_addr;
  logic [WIDTH-1:0] w_rd_next_data;

  // full gates the push even when a pop happens in the same cycle.
  assign w_push = write_data & ~r_full;
  assign w_pop  = r_data_valid & data_ready;
  assign w_op   = ob_op_e'({w_push, w_pop});

  // The entry behind the head becomes the new head on a pop.
  assign w_rd_next_addr = r_rd_ptr + PTR_W'(1);

  output_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_to_write),
    .i_rd_addr (w_rd_next_addr),
    .o_rd_data (w_rd_next_data)
  );

  // Next occupancy and next head word from this cycle's push/pop.
  always_comb begin
    w_count_next = r_count;
    w_data_next  = r_data;
    case (w_op)
      OP_PUSH: begin
        w_count_next = r_count + CNT_W'(1);
        if (r_count == CNT_W'(0)) begin
          w_data_next = data_to_write;
        end else begin
          w_data_next = r_data;
        end
      end
      OP_POP: begin
        w_count_next = r_count - CNT_W'(1);
        if (r_count > CNT_W'(1)) begin
          w_data_next = w_rd_next_data;
        end else begin
          // Last word popped: hold it on data until the next push.
          w_data_next = r_data;
        end
      end
      OP_BOTH: begin
        w_count_next = r_count;
        if (r_count > CNT_W'(1)) begin
          w_data_next = w_rd_next_data;
        end else begin
          // Sole entry leaves as the new word arrives, which becomes head.
          w_data_next = data_to_write;
        end
      end
      default: begin
        w_count_next = r_count;
        w_data_next  = r_data;
      end
    endcase
  end

  // Pointers, occupancy, head register and flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr     <= PTR_W'(0);
      r_rd_ptr     <= PTR_W'(0);
      r_count      <= CNT_W'(0);
      r_data       <= WIDTH'(0);
      r_data_valid <= 1'b0;
      r_full       <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count      <= w_count_next;
      r_data       <= w_data_next;
      r_data_valid <= (w_count_next != CNT_W'(0));
      r_full       <= (w_count_next == CNT_W'(DEPTH));
      // A dropped push wins over a same-cycle clear.
      if (write_data && r_full) begin
        r_overflow <= 1'b1;
      end else if (clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign full       = r_full;
  assign count      = r_count;
  assign overflow   = r_overflow;

endmodule : output_buffer

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer against a queue-based reference.
module tb_output_buffer;

  localparam int W = 256;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         write_data = 1'b0;
  logic [W-1:0] data_to_write = '0;
  logic         data_ready = 1'b0;
  logic         clear_overflow = 1'b0;
  logic [W-1:0] data;
  logic         data_valid;
  logic         full;
  logic [2:0]   count;
  logic         overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: queue contents, word shown on data, sticky overflow.
  logic [W-1:0] mq[$];
  logic [W-1:0] m_shown;
  logic         m_ovf;

  output_buffer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .write_data     (write_data),
    .data_to_write  (data_to_write),
    .data_ready     (data_ready),
    .clear_overflow (clear_overflow),
    .data           (data),
    .data_valid     (data_valid),
    .full           (full),
    .count          (count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic rn, input logic wd, input logic [W-1:0] din,
                       input logic rdy, input logic clr);
    logic was_full;
    logic do_push;
    logic do_pop;
    logic [W-1:0] dummy;
    reset_n        = rn;
    write_data     = wd;
    data_to_write  = din;
    data_ready     = rdy;
    clear_overflow = clr;
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_shown = '0;
      m_ovf   = 1'b0;
    end else begin
      was_full = (mq.size() == D);
      do_push  = wd && !was_full;
      do_pop   = rdy && (mq.size() != 0);
      if (wd && was_full) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (do_pop) dummy = mq.pop_front();
      if (do_push) mq.push_back(din);
      if (mq.size() != 0) m_shown = mq[0];
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, W'(32'hDEAD), 1'b1, 1'b1);
    total++; if (data !== W'(0)) begin bad++; $display("FAIL reset_data got=%h exp=0", data); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_single_push();
    cycle(1'b1, 1'b1, W'(26'h5555555), 1'b0, 1'b0);
    cycle(1'b1, 1'b0, W'(0), 1'b0, 1'b0);
    total++; if (data !== W'(26'h5555555)) begin bad++; $display("FAIL single_data got=%h exp=5555555", data); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
  endtask

  task automatic test_fill_overflow();
    logic [W-1:0] vals [5];
    vals[0] = W'(26'hAAAAAAA); vals[1] = W'(1); vals[2] = W'(2); vals[3] = W'(3); vals[4] = W'(4);
    cycle(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, vals[i], 1'b0, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_early got=%b exp=0", overflow); end
    cycle(1'b1, 1'b1, vals[4], 1'b0, 1'b0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%b exp=1", overflow); end
    total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", count); end
    total++; if (data !== W'(26'hAAAAAAA)) begin bad++; $display("FAIL fill_head got=%h exp=aaaaaaa", data); end
  endtask

  task automatic test_drain();
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = W'(26'hAAAAAAA); exp_seq[1] = W'(1); exp_seq[2] = W'(2); exp_seq[3] = W'(3);
    for (int i = 0; i < 4; i++) begin
      total++; if (data !== exp_seq[i]) begin bad++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data, exp_seq[i]); end
      cycle(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
    end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", data_valid); end
    total++; if (data !== W'(3)) begin bad++; $display("FAIL drain_hold got=%h exp=3", data); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drain_ovf_sticky got=%b exp=1", overflow); end
    // Ready while empty must not disturb anything.
    cycle(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
    total++; if (count !== 3'd0 || data !== W'(3)) begin bad++; $display("FAIL ready_empty count=%0d data=%h exp 0/3", count, data); end
    cycle(1'b1, 1'b0, W'(0), 1'b0, 1'b1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_simul_push_pop();
    cycle(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(10), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(11), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(12), 1'b1, 1'b0);
    total++; if (count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", count); end
    total++; if (data !== W'(11)) begin bad++; $display("FAIL simul_data0 got=%h exp=11", data); end
    cycle(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
    total++; if (data !== W'(12) || count !== 3'd1) begin bad++; $display("FAIL simul_data1 got=%h/%0d exp=12/1", data, count); end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, W'(20 + i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(99), 1'b1, 1'b0);
    total++; if (count !== 3'd3) begin bad++; $display("FAIL fullpp_count got=%0d exp=3", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fullpp_ovf got=%b exp=1", overflow); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL fullpp_full got=%b exp=0", full); end
    // Overflow again at full with clear in the same cycle: set wins.
    cycle(1'b1, 1'b1, W'(24), 1'b0, 1'b1);
    cycle(1'b1, 1'b1, W'(98), 1'b0, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      total++; if (data !== W'(21 + i)) begin bad++; $display("FAIL fullpp_order[%0d] got=%h exp=%h", i, data, W'(21 + i)); end
      cycle(1'b1, 1'b0, W'(0), 1'b1, 1'b0);
    end
  endtask

  task automatic test_wrap();
    cycle(1'b0, 1'b0, W'(0), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(100), 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b1, W'(100 + i), 1'b1, 1'b0);
      total++; if (data !== W'(100 + i) || count !== 3'd1) begin bad++; $display("FAIL wrap[%0d] got=%h/%0d exp=%h/1", i, data, count, W'(100 + i)); end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b1, W'(1), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, W'(2), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, W'(5), 1'b1, 1'b1);
    total++; if (data !== W'(0) || data_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 || overflow !== 1'b0)
      begin bad++; $display("FAIL reset_mid data=%h v=%b c=%0d f=%b o=%b exp all 0", data, data_valid, count, full, overflow); end
    cycle(1'b1, 1'b1, W'(7), 1'b0, 1'b0);
    total++; if (data !== W'(7) || data_valid !== 1'b1) begin bad++; $display("FAIL reset_mid_push got=%h/%b exp=7/1", data, data_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] din;
    logic exp_valid;
    for (int i = 0; i < 400; i++) begin
      din = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0), din,
            ($urandom_range(0, 1) != 0), ($urandom_range(0, 7) == 0));
      exp_valid = (mq.size() != 0);
      total++;
      if (data !== m_shown || data_valid !== exp_valid || count !== 3'(mq.size()) ||
          full !== (mq.size() == D) || overflow !== m_ovf) begin
        bad++;
        $display("FAIL random[%0d] got d=%h v=%b c=%0d f=%b o=%b exp d=%h v=%b c=%0d o=%b",
                 i, data[31:0], data_valid, count, full, overflow, m_shown[31:0], exp_valid, mq.size(), m_ovf);
      end
    end
  endtask

  initial begin
    m_shown = '0;
    m_ovf   = 1'b0;
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_drain();
    test_simul_push_pop();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_output_buffer
